// File: rtl/param_control.sv
// Multi-cycle register-file datapath: load/move in one step, ALU ops in three.
// A shared bus carries operands through accumulator A and result register G.
module param_control #(
    parameter int WIDTH = 4,
    parameter int NREG  = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic [2:0]       func,
    input  logic [RW-1:0]    rx,
    input  logic [RW-1:0]    ry,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] reg_val0,
    output logic [WIDTH-1:0] reg_val1,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic [1:0]       curr_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b011;
    localparam logic [2:0] F_AND = 3'b100;
    localparam logic [2:0] F_OR  = 3'b101;
    localparam logic [2:0] F_XOR = 3'b110;
    localparam logic [2:0] F_SHL = 3'b111;
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    state_t           r_state;
    logic [2:0]       r_func;
    logic [RW-1:0]    r_rx;
    logic [RW-1:0]    r_ry;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_g;
    logic             r_carry;

    logic             w_xfer;
    logic [WIDTH-1:0] w_bus;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;

    // load and move finish in T1; everything else runs the 3-step ALU path
    assign w_xfer = (r_func[2:1] == 2'b00);

    always_comb begin
        w_bus = '0;
        unique case (r_state)
            IDLE: w_bus = '0;
            T1: begin
                if (r_func == 3'b000)      w_bus = r_data;
                else if (r_func == 3'b001) w_bus = r_regs[r_ry];
                else                       w_bus = r_regs[r_rx];
            end
            T2: w_bus = r_regs[r_ry];
            T3: w_bus = r_g;
        endcase
    end

    always_comb begin
        w_sum  = '0;
        w_res  = r_a;
        w_cout = r_carry;
        unique case (r_func)
            F_ADD: begin
                w_sum  = {1'b0, r_a} + {1'b0, w_bus};
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
            end
            F_SUB: begin
                // carry out of A + ~B + 1 is the "no borrow" flag
                w_sum  = {1'b0, r_a} + {1'b0, ~w_bus} + ONE;
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
            end
            F_AND: w_res = r_a & w_bus;
            F_OR:  w_res = r_a | w_bus;
            F_XOR: w_res = r_a ^ w_bus;
            F_SHL: begin
                w_res  = {r_a[WIDTH-2:0], 1'b0};
                w_cout = r_a[WIDTH-1];
            end
            default: w_res = r_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_func  <= '0;
            r_rx    <= '0;
            r_ry    <= '0;
            r_data  <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_carry <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w) begin
                        r_func  <= func;
                        r_rx    <= rx;
                        r_ry    <= ry;
                        r_data  <= data;
                        r_state <= T1;
                    end
                end
                T1: begin
                    if (w_xfer) begin
                        r_regs[r_rx] <= w_bus;
                        r_state      <= IDLE;
                    end else begin
                        r_a     <= w_bus;
                        r_state <= T2;
                    end
                end
                T2: begin
                    r_g     <= w_res;
                    r_carry <= w_cout;
                    r_state <= T3;
                end
                T3: begin
                    r_regs[r_rx] <= r_g;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus        = w_bus;
    assign reg_val0   = r_regs[0];
    assign reg_val1   = r_regs[1];
    assign busy       = (r_state != IDLE);
    assign done       = ((r_state == T1) && w_xfer) || (r_state == T3);
    assign carry      = r_carry;
    assign curr_state = r_state;

endmodule

// File: tb/tb_param_control.sv
// Directed bench for param_control (WIDTH=4, NREG=8).
// Expected values below are hand-computed from the instruction semantics.
module tb_param_control;

    logic       clk;
    logic       rst;
    logic       w;
    logic [2:0] func;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [3:0] data;
    logic [3:0] bus;
    logic [3:0] reg_val0;
    logic [3:0] reg_val1;
    logic       busy;
    logic       done;
    logic       carry;
    logic [1:0] curr_state;

    int n_checks = 0;
    int n_errors = 0;

    param_control #(.WIDTH(4), .NREG(8)) dut (
        .clk(clk),
        .rst(rst),
        .w(w),
        .func(func),
        .rx(rx),
        .ry(ry),
        .data(data),
        .bus(bus),
        .reg_val0(reg_val0),
        .reg_val1(reg_val1),
        .busy(busy),
        .done(done),
        .carry(carry),
        .curr_state(curr_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present an instruction for exactly one accepting edge
    task automatic issue(input logic [2:0] f, input logic [2:0] x,
                         input logic [2:0] y, input logic [3:0] d);
        w    = 1'b1;
        func = f;
        rx   = x;
        ry   = y;
        data = d;
        step();
        w = 1'b0;
    endtask

    task automatic load(input logic [2:0] x, input logic [3:0] d);
        issue(3'b000, x, 3'd0, d);
        step();
    endtask

    initial begin
        rst  = 1'b0;
        w    = 1'b0;
        func = 3'b000;
        rx   = 3'd0;
        ry   = 3'd0;
        data = 4'd0;
        #1;
        check("rst_state", 8'(curr_state), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_bus", 8'(bus), 8'd0);
        check("rst_r0", 8'(reg_val0), 8'd0);
        check("rst_carry", 8'(carry), 8'd0);
        step();
        step();
        rst = 1'b1;

        // load R0 <= 0001
        issue(3'b000, 3'd0, 3'd0, 4'b0001);
        check("ld0_t1_state", 8'(curr_state), 8'd1);
        check("ld0_t1_done", 8'(done), 8'd1);
        check("ld0_t1_bus", 8'(bus), 8'h1);
        check("ld0_t1_busy", 8'(busy), 8'd1);
        step();
        check("ld0_idle_state", 8'(curr_state), 8'd0);
        check("ld0_idle_done", 8'(done), 8'd0);
        check("ld0_idle_bus", 8'(bus), 8'd0);
        check("ld0_r0", 8'(reg_val0), 8'h1);

        // load R1 <= 1000
        issue(3'b000, 3'd1, 3'd0, 4'b1000);
        check("ld1_t1_done", 8'(done), 8'd1);
        step();
        check("ld1_r1", 8'(reg_val1), 8'h8);

        // move R1 <= R0
        issue(3'b001, 3'd1, 3'd0, 4'hF);
        check("mv_t1_bus", 8'(bus), 8'h1);
        check("mv_t1_done", 8'(done), 8'd1);
        step();
        check("mv_r1", 8'(reg_val1), 8'h1);
        check("mv_r0", 8'(reg_val0), 8'h1);

        // add R0,R1 : 9 + 8 = 17 -> 1, carry 1
        load(3'd0, 4'b1001);
        load(3'd1, 4'b1000);
        issue(3'b010, 3'd0, 3'd1, 4'h0);
        check("add_t1_bus", 8'(bus), 8'h9);
        check("add_t1_done", 8'(done), 8'd0);
        step();
        check("add_t2_state", 8'(curr_state), 8'd2);
        check("add_t2_bus", 8'(bus), 8'h8);
        check("add_t2_done", 8'(done), 8'd0);
        step();
        check("add_t3_state", 8'(curr_state), 8'd3);
        check("add_t3_bus", 8'(bus), 8'h1);
        check("add_t3_done", 8'(done), 8'd1);
        step();
        check("add_r0", 8'(reg_val0), 8'h1);
        check("add_carry", 8'(carry), 8'd1);
        check("add_done_clr", 8'(done), 8'd0);

        // sub R0,R1 : 3 - 5 = 1110, carry 0
        load(3'd0, 4'b0011);
        load(3'd1, 4'b0101);
        issue(3'b011, 3'd0, 3'd1, 4'h0);
        step();
        step();
        step();
        check("sub_r0", 8'(reg_val0), 8'hE);
        check("sub_carry", 8'(carry), 8'd0);

        // xor R0,R0 -> 0, carry unchanged
        issue(3'b110, 3'd0, 3'd0, 4'h0);
        step();
        step();
        step();
        check("xor_r0", 8'(reg_val0), 8'h0);
        check("xor_carry", 8'(carry), 8'd0);

        // shl R1 : 1010 -> 0100, carry 1; w wiggles mid-instruction
        load(3'd1, 4'b1010);
        issue(3'b111, 3'd1, 3'd2, 4'h0);
        w    = 1'b1;
        func = 3'b000;
        rx   = 3'd0;
        data = 4'hF;
        step();
        w = 1'b0;
        step();
        check("shl_t3_state", 8'(curr_state), 8'd3);
        w = 1'b1;
        step();
        w = 1'b0;
        check("shl_r1", 8'(reg_val1), 8'h4);
        check("shl_carry", 8'(carry), 8'd1);
        check("shl_r0_kept", 8'(reg_val0), 8'h0);
        check("shl_state_idle", 8'(curr_state), 8'd0);

        // or R0,R1 : 0 | 4 = 4, carry stays 1
        issue(3'b101, 3'd0, 3'd1, 4'h0);
        step();
        step();
        step();
        check("or_r0", 8'(reg_val0), 8'h4);
        check("or_carry", 8'(carry), 8'd1);

        // add R1,R1 : 4 + 4 = 8, carry 0
        issue(3'b010, 3'd1, 3'd1, 4'h0);
        step();
        step();
        step();
        check("dbl_r1", 8'(reg_val1), 8'h8);
        check("dbl_carry", 8'(carry), 8'd0);

        // sub R1,R1 : equal operands -> 0, carry 1
        issue(3'b011, 3'd1, 3'd1, 4'h0);
        step();
        step();
        step();
        check("subeq_r1", 8'(reg_val1), 8'h0);
        check("subeq_carry", 8'(carry), 8'd1);

        // add R0,R0 aborted by reset in T2
        issue(3'b010, 3'd0, 3'd0, 4'h0);
        step();
        check("abort_t2_state", 8'(curr_state), 8'd2);
        #2;
        rst = 1'b0;
        #1;
        check("abort_state", 8'(curr_state), 8'd0);
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_bus", 8'(bus), 8'd0);
        check("abort_done", 8'(done), 8'd0);
        check("abort_r0", 8'(reg_val0), 8'h0);
        check("abort_carry", 8'(carry), 8'd0);
        step();
        check("abort_no_wb", 8'(reg_val0), 8'h0);
        rst = 1'b1;
        issue(3'b000, 3'd0, 3'd0, 4'h7);
        check("post_rst_t1", 8'(curr_state), 8'd1);
        step();
        check("post_rst_r0", 8'(reg_val0), 8'h7);

        // w held high re-issues load R1 <= 0011 every IDLE cycle
        w    = 1'b1;
        func = 3'b000;
        rx   = 3'd1;
        data = 4'b0011;
        step();
        check("hold_t1_a", 8'(curr_state), 8'd1);
        step();
        check("hold_idle", 8'(curr_state), 8'd0);
        check("hold_r1", 8'(reg_val1), 8'h3);
        step();
        check("hold_t1_b", 8'(curr_state), 8'd1);
        w = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/param_control.md
PARAM_CONTROL -- requirements
Module: param_control

Interface
REQ-001 Parameter WIDTH, default 4, data/register width in bits (>=2).
REQ-002 Parameter NREG, default 8, general register count (power of 2, >=2); RW = clog2(NREG).
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 w  input  1  instruction valid; sampled only in IDLE.
REQ-006 func  input  3  opcode: 000 load, 001 move, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 shl.
REQ-007 rx  input  RW  destination/first-operand register index.
REQ-008 ry  input  RW  second-operand register index.
REQ-009 data  input  WIDTH  immediate for load.
REQ-010 bus  output  WIDTH  internal datapath bus value for the current cycle.
REQ-011 reg_val0 / reg_val1  output  WIDTH each  live contents of R0 / R1.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 done  output  1  high during the final cycle of every instruction.
REQ-014 carry  output  1  carry flag register.
REQ-015 curr_state  output  2  state encoding: IDLE=0, T1=1, T2=2, T3=3.

Function
REQ-016 The block shall hold NREG general registers R0..R(NREG-1), an accumulator A and a result register G, all WIDTH bits.
REQ-017 In IDLE with w=1 at a rising edge, func/rx/ry/data shall be latched into an instruction register and state shall go to T1; inputs are ignored in all other states.
REQ-018 Load: T1 drives bus=data, done=1; Rx<=data at the edge ending T1; next state IDLE (latency 2 edges from acceptance to write-back).
REQ-019 Move: T1 drives bus=Ry, done=1; Rx<=Ry at the edge ending T1; next state IDLE.
REQ-020 ALU ops: T1 bus=Rx, A<=bus; T2 bus=Ry, G<=A op bus; T3 bus=G, done=1, Rx<=G; next state IDLE.
REQ-021 Arithmetic modulo 2^WIDTH; add carry = carry-out of A+Ry; sub computes A+~Ry+1, carry=1 iff A>=Ry (unsigned).
REQ-022 shl: G = A<<1 with LSB 0, carry = A[WIDTH-1]; Ry is driven on bus in T2 but not used.
REQ-023 and/or/xor, load, move shall leave carry unchanged; carry updates only at the edge ending T2.
REQ-024 rx==ry shall be legal: operands read before write-back (e.g. add R1,R1 doubles R1).
REQ-025 bus shall be all zeros in IDLE.
REQ-026 done shall be a single-cycle pulse; the cycle after done is always IDLE, so minimum spacing between accepted instructions is 2 cycles (load/move) or 4 cycles (ALU).
REQ-027 w held high continuously shall re-issue the presented instruction on each IDLE cycle.

Reset
REQ-028 rst=0 shall immediately force state IDLE, all Rn/A/G/instruction register to 0, carry=0, done=0, busy=0, bus=0, independent of clk.
REQ-029 Reset asserted mid-instruction shall abort it with no write-back; first acceptance possible on the first rising edge with rst=1.

Verification (WIDTH=4, NREG=8)
REQ-030 Reset then load R0<=0001, load R1<=1000 -> reg_val0=0001, reg_val1=1000, done pulsed once per load, curr_state 0->1->0.
REQ-031 Move R1<=R0 with R0=0001 -> reg_val1=0001 after 2 edges; R0 unchanged.
REQ-032 R0=1001, R1=1000, add R0,R1 -> bus 1001,1000,0001 in T1/T2/T3; reg_val0=0001, carry=1, done only in T3.
REQ-033 R0=0011, R1=0101, sub R0,R1 -> R0=1110, carry=0; then xor R0,R0 -> R0=0000, carry still 0.
REQ-034 R1=1010, shl R1 -> R1=0100, carry=1; w toggled during T1-T3 has no effect.
REQ-035 Start add, assert rst=0 in T2 -> outputs zero immediately, no write-back; after release new load accepted on the next edge.
